// File: rtl/sap1_controller_sequencer_if.sv
// Opcode/control-word bundle between the SAP-1 sequencer and its datapath.
// With SAP1_SINGLE_STEP_EN defined, the MANUAL/STEP single-step controls are added.
interface sap1_controller_sequencer_if;
    logic [3:0]  opcode;
    logic [11:0] CON;
    logic [5:0]  T;
    logic        nHLT;
`ifdef SAP1_SINGLE_STEP_EN
    logic        MANUAL;
    logic        STEP;
`endif

`ifdef SAP1_SINGLE_STEP_EN
    modport master (output opcode, output MANUAL, output STEP,
                    input CON, input T, input nHLT);
    modport slave  (input opcode, input MANUAL, input STEP,
                    output CON, output T, output nHLT);
`else
    modport master (output opcode, input CON, input T, input nHLT);
    modport slave  (input opcode, output CON, output T, output nHLT);
`endif
endinterface

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: falling-edge 6-state ring counter, opcode decode, halt latch.
// Optional single-step control is compiled in with SAP1_SINGLE_STEP_EN.
module sap1_controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input logic                      CLK,
    input logic                      CLR,
    sap1_controller_sequencer_if.slave bus
);
    localparam logic [11:0] CON_NOP = 12'h3E3;

    typedef enum logic [5:0] {
        S_T1 = 6'b000001,
        S_T2 = 6'b000010,
        S_T3 = 6'b000100,
        S_T4 = 6'b001000,
        S_T5 = 6'b010000,
        S_T6 = 6'b100000
    } state_t;

    state_t      state_q, state_d;
    logic        halted_q;
    logic        advance;
    logic        halt_now;
    logic [11:0] con_w;

`ifdef SAP1_SINGLE_STEP_EN
    logic step_s1_q, step_s2_q, step_prev_q;
    assign advance = !bus.MANUAL || (step_s2_q && !step_prev_q);
`else
    assign advance = 1'b1;
`endif

    assign halt_now = (state_q == S_T4) && (bus.opcode == OP_HLT);

    always_comb begin
        state_d = S_T1;
        case (state_q)
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_T1;
            default: state_d = S_T1;
        endcase
    end

    // Halt is checked before the step gate so a pending HLT freezes the ring regardless of MANUAL.
    always_ff @(negedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q  <= S_T1;
            halted_q <= 1'b0;
`ifdef SAP1_SINGLE_STEP_EN
            step_s1_q   <= 1'b0;
            step_s2_q   <= 1'b0;
            step_prev_q <= 1'b0;
`endif
        end else begin
`ifdef SAP1_SINGLE_STEP_EN
            step_s1_q   <= bus.STEP;
            step_s2_q   <= step_s1_q;
            step_prev_q <= step_s2_q;
`endif
            if (!halted_q) begin
                if (halt_now)
                    halted_q <= 1'b1;
                else if (advance)
                    state_q <= state_d;
            end
        end
    end

    always_comb begin
        con_w = CON_NOP;
        if (CLR && !halted_q) begin
            case (state_q)
                S_T1: con_w = 12'h5E3;
                S_T2: con_w = 12'hBE3;
                S_T3: con_w = 12'h263;
                S_T4: begin
                    if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB)
                        con_w = 12'h1A3;
                    else if (bus.opcode == OP_OUT)
                        con_w = 12'h3F2;
                end
                S_T5: begin
                    if (bus.opcode == OP_LDA)
                        con_w = 12'h2C3;
                    else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB)
                        con_w = 12'h2E1;
                end
                S_T6: begin
                    if (bus.opcode == OP_ADD)
                        con_w = 12'h3C7;
                    else if (bus.opcode == OP_SUB)
                        con_w = 12'h3CF;
                end
                default: con_w = CON_NOP;
            endcase
        end
    end

    assign bus.CON  = con_w;
    assign bus.T    = state_q;
    assign bus.nHLT = !(CLR && (halted_q || halt_now));
endmodule

// File: doc/sap1_controller_sequencer.md
Name: sap1_controller_sequencer

Overview:
- Controller/sequencer for the SAP-1 datapath.
- A 6-state ring counter (T1..T6) steps through the fetch and execute phases. The 4-bit opcode from the instruction register is decoded into the 12-bit control word that drives the program counter, MAR, RAM, IR, accumulator, adder/subtractor, B register and output register.
- Also generates the halt signal that stops the system.

Parameters:
- OP_LDA, 4'h0, opcode for load accumulator from memory
- OP_ADD, 4'h1, opcode for add memory operand to accumulator
- OP_SUB, 4'h2, opcode for subtract memory operand from accumulator
- OP_OUT, 4'hE, opcode for copy accumulator to output register
- OP_HLT, 4'hF, opcode for halt

Ports:
- CLK  input  1  system clock; state advances on the falling edge
- CLR  input  1  asynchronous active-low reset
- opcode  input  4  upper nibble of the instruction register
- CON  output  12  control word, bit order {Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo}
- T  output  6  one-hot ring state; T[0]=T1 ... T[5]=T6
- nHLT  output  1  active-low halt to the clock gate

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - CLR low immediately forces T=6'b000001, clears the halted flag and forces CON=12'h3E3 (NOP) while CLR is held low.
  - nHLT=1 during reset.
- Ring counter:
  - Advances on every falling edge of CLK: T1→T2→T3→T4→T5→T6→T1.
  - All datapath registers load on the rising edge. This timing keeps CON stable for half a cycle before each load.
- CON decoding:
  - Combinational from T and opcode; no extra latency.
  - Inactive/NOP word = 12'h3E3.
- Fetch (all opcodes):
  - T1 = 5E3 (Ep, nLm)
  - T2 = BE3 (Cp)
  - T3 = 263 (nCE, nLi)
- Execute (T4/T5/T6):
  - LDA: 1A3 / 2C3 / 3E3
  - ADD: 1A3 / 2E1 / 3C7
  - SUB: 1A3 / 2E1 / 3CF
  - OUT: 3F2 / 3E3 / 3E3
  - Any other opcode (except HLT): 3E3 in T4-T6; treated as NOP, counter continues.
- Opcode sampling:
  - opcode is read only in T4-T6. Its value in T1-T3 is ignored.
  - The IR is loaded at the rising edge inside T3.
- HLT:
  - In T4 with opcode==OP_HLT: CON=3E3 and nHLT goes low combinationally.
  - At the next falling edge the halted flag is set and T stays at T4 (ring frozen).
  - While halted: CON=3E3, nHLT=0, opcode changes ignored.
  - Only CLR exits halt.
- Reset mid-instruction: abandons the instruction immediately; the next instruction restarts at T1.
- Output cleanliness: exactly one T bit set at all times; no X on CON after reset.

Optional Feature:
- Macro: SAP1_SINGLE_STEP_EN.
- With the macro defined, two extra inputs are added:
  - MANUAL (1)
  - STEP (1), synchronised by a 2-flop stage on the falling edge.
- Single-step behaviour when defined:
  - MANUAL=1: the ring counter advances only on a falling edge where a rising edge of the synchronised STEP is detected. Otherwise T holds, and CON holds its decoded value for the current T.
  - MANUAL=0: free-running behaviour as above.
  - CLR also clears the synchroniser and edge detector.
  - Halt still has priority: once halted, STEP has no effect.
- Without the macro: no extra ports; the counter always free-runs.

Test Plan:
- Reset: CLR=0 mid-T5, then release → T=000001 and CON=3E3 while low; CON=5E3 after release; nHLT=1.
- Fetch + LDA: opcode=0 → CON sequence 5E3, BE3, 263, 1A3, 2C3, 3E3 on successive half-cycle-offset windows; T returns to 000001.
- ADD then SUB: opcode=1 then 2 → T6 words 3C7 then 3CF; T4/T5 words 1A3/2E1 for both.
- OUT and undefined opcode: opcode=E → T4=3F2, T5/T6=3E3. Opcode=7 → T4-T6=3E3 and the counter keeps cycling.
- HLT: opcode=F at T4 → nHLT=0 within the same cycle; T stays 001000 for ≥10 cycles; CON=3E3; changing opcode to 0 has no effect; CLR pulse → T=000001, nHLT=1.
- Single step (SAP1_SINGLE_STEP_EN): MANUAL=1, STEP low for 8 cycles → T unchanged. Three STEP pulses → T advances exactly 3 states. MANUAL=0 → free-run resumes.
